// File: rtl/wb_stage_if.sv
// Bundle between EX/MEM, data memory and the write-back stage of the venus pipeline.
interface wb_stage_if;
   logic        ex_valid_i;
   logic        ex_wen_i;
   logic        ex_ld_i;
   logic [3:0]  ex_rd_i;
   logic [31:0] ex_result_i;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
   logic        err_clr_i;
   logic        wb_o;
   logic [3:0]  wb_r_o;
   logic [31:0] wb_data_o;
   logic        stall_o;
   logic [31:0] retired_o;
   logic        err_o;

   modport master (
      output ex_valid_i, ex_wen_i, ex_ld_i, ex_rd_i, ex_result_i,
      output dmem_rvalid_i, dmem_rdata_i, err_clr_i,
      input  wb_o, wb_r_o, wb_data_o, stall_o, retired_o, err_o
   );

   modport slave (
      input  ex_valid_i, ex_wen_i, ex_ld_i, ex_rd_i, ex_result_i,
      input  dmem_rvalid_i, dmem_rdata_i, err_clr_i,
      output wb_o, wb_r_o, wb_data_o, stall_o, retired_o, err_o
   );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: registered ALU write-back, load wait with upstream stall, retire counter, sticky error.
// Optional load abandonment after LOAD_TIMEOUT cycles is enabled by defining WB_LOAD_TIMEOUT_EN.
module wb_stage #(
   parameter int LOAD_TIMEOUT = 255,
   parameter int W_TO         = 8
) (
   input  logic     clk,
   input  logic     rst,
   wb_stage_if.slave bus
);

   typedef enum logic [0:0] {
      IDLE      = 1'b0,
      LOAD_WAIT = 1'b1
   } state_t;

   state_t      state_r, state_s;
   logic        wb_r, wb_s;
   logic [3:0]  wb_rd_r, wb_rd_s;
   logic [31:0] wb_data_r, wb_data_s;
   logic [31:0] retired_r;
   logic        retire_s;
   logic        err_r, err_s, err_set_s;
   logic [3:0]  ld_rd_r, ld_rd_s;
   logic        stall_s;
   logic        accept_s;

`ifdef WB_LOAD_TIMEOUT_EN
   localparam logic [W_TO-1:0] TO_LAST = W_TO'(LOAD_TIMEOUT - 1);
   logic [W_TO-1:0] to_cnt_r, to_cnt_s;
`endif

   assign stall_s  = (state_r == LOAD_WAIT);
   assign accept_s = bus.ex_valid_i & ~stall_s;

   // Next-state, write-back and error-event decode
   always_comb begin
      state_s   = state_r;
      wb_s      = 1'b0;
      wb_rd_s   = wb_rd_r;
      wb_data_s = wb_data_r;
      retire_s  = 1'b0;
      err_set_s = 1'b0;
      ld_rd_s   = ld_rd_r;
`ifdef WB_LOAD_TIMEOUT_EN
      to_cnt_s  = to_cnt_r;
`endif
      case (state_r)
         IDLE: begin
            // rvalid with no load outstanding never carries data
            if (bus.dmem_rvalid_i) begin
               err_set_s = 1'b1;
            end else begin
               err_set_s = 1'b0;
            end
            if (accept_s) begin
               if (bus.ex_ld_i) begin
                  ld_rd_s = bus.ex_rd_i;
                  state_s = LOAD_WAIT;
`ifdef WB_LOAD_TIMEOUT_EN
                  to_cnt_s = {W_TO{1'b0}};
`endif
               end else if (bus.ex_wen_i) begin
                  wb_s      = 1'b1;
                  wb_rd_s   = bus.ex_rd_i;
                  wb_data_s = bus.ex_result_i;
                  retire_s  = 1'b1;
               end else begin
                  retire_s  = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         LOAD_WAIT: begin
            if (bus.dmem_rvalid_i) begin
               wb_s      = 1'b1;
               wb_rd_s   = ld_rd_r;
               wb_data_s = bus.dmem_rdata_i;
               retire_s  = 1'b1;
               state_s   = IDLE;
            end else begin
`ifdef WB_LOAD_TIMEOUT_EN
               if (to_cnt_r == TO_LAST) begin
                  err_set_s = 1'b1;
                  state_s   = IDLE;
               end else begin
                  to_cnt_s  = to_cnt_r + {{(W_TO-1){1'b0}}, 1'b1};
               end
`else
               state_s = LOAD_WAIT;
`endif
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Set wins over clear when both happen in the same cycle
   always_comb begin
      if (err_set_s) begin
         err_s = 1'b1;
      end else if (bus.err_clr_i) begin
         err_s = 1'b0;
      end else begin
         err_s = err_r;
      end
   end

   // Stage state and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= IDLE;
         wb_r      <= 1'b0;
         wb_rd_r   <= 4'd0;
         wb_data_r <= 32'd0;
         retired_r <= 32'd0;
         err_r     <= 1'b0;
         ld_rd_r   <= 4'd0;
      end else begin
         state_r   <= state_s;
         wb_r      <= wb_s;
         wb_rd_r   <= wb_rd_s;
         wb_data_r <= wb_data_s;
         retired_r <= retired_r + {31'd0, retire_s};
         err_r     <= err_s;
         ld_rd_r   <= ld_rd_s;
      end
   end

`ifdef WB_LOAD_TIMEOUT_EN
   // Load timeout counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         to_cnt_r <= {W_TO{1'b0}};
      end else begin
         to_cnt_r <= to_cnt_s;
      end
   end
`endif

   assign bus.wb_o      = wb_r;
   assign bus.wb_r_o    = wb_rd_r;
   assign bus.wb_data_o = wb_data_r;
   assign bus.stall_o   = stall_s;
   assign bus.retired_o = retired_r;
   assign bus.err_o     = err_r;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; timeout steps run only when WB_LOAD_TIMEOUT_EN is defined.
module tb_wb_stage;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   logic [31:0] exp_ret;

   wb_stage_if bus ();

   wb_stage #(.LOAD_TIMEOUT(4), .W_TO(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic wen, input logic ld, input logic [3:0] rd,
                        input logic [31:0] res, input logic rv, input logic [31:0] rdata,
                        input logic clr);
      bus.ex_valid_i    = v;
      bus.ex_wen_i      = wen;
      bus.ex_ld_i       = ld;
      bus.ex_rd_i       = rd;
      bus.ex_result_i   = res;
      bus.dmem_rvalid_i = rv;
      bus.dmem_rdata_i  = rdata;
      bus.err_clr_i     = clr;
   endtask

   task automatic idle_in();
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_wb(input string tag, input logic wb, input logic [3:0] rd, input logic [31:0] data);
      chk({tag, "_wb"}, {31'd0, bus.wb_o}, {31'd0, wb});
      chk({tag, "_rd"}, {28'd0, bus.wb_r_o}, {28'd0, rd});
      chk({tag, "_data"}, bus.wb_data_o, data);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      exp_ret  = 32'd0;
      rst      = 1'b0;
      idle_in();
      tick();
      tick();
      chk_wb("reset", 1'b0, 4'd0, 32'd0);
      chk("reset_stall", {31'd0, bus.stall_o}, 32'd0);
      chk("reset_retired", bus.retired_o, 32'd0);
      chk("reset_err", {31'd0, bus.err_o}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // ALU write rd=3
      drive(1'b1, 1'b1, 1'b0, 4'd3, 32'h1234_5678, 1'b0, 32'd0, 1'b0);
      tick();
      exp_ret = exp_ret + 32'd1;
      chk_wb("alu", 1'b1, 4'd3, 32'h1234_5678);
      chk("alu_retired", bus.retired_o, exp_ret);
      idle_in();
      tick();
      chk_wb("alu_hold", 1'b0, 4'd3, 32'h1234_5678);

      // Load rd=5, data after three empty wait cycles; ALU op rd=7 held behind it
      drive(1'b1, 1'b0, 1'b1, 4'd5, 32'hDEAD_0000, 1'b0, 32'd0, 1'b0);
      tick();
      chk("ld_stall0", {31'd0, bus.stall_o}, 32'd1);
      chk("ld_nowb", {31'd0, bus.wb_o}, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 4'd7, 32'h0000_00A5, 1'b0, 32'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ld_stall_wait", {31'd0, bus.stall_o}, 32'd1);
         chk("ld_wait_nowb", {31'd0, bus.wb_o}, 32'd0);
      end
      chk("ld_wait_retired", bus.retired_o, exp_ret);
      drive(1'b1, 1'b1, 1'b0, 4'd7, 32'h0000_00A5, 1'b1, 32'hCAFE_BABE, 1'b0);
      tick();
      exp_ret = exp_ret + 32'd1;
      chk_wb("ld_done", 1'b1, 4'd5, 32'hCAFE_BABE);
      chk("ld_done_stall", {31'd0, bus.stall_o}, 32'd0);
      chk("ld_done_retired", bus.retired_o, exp_ret);
      drive(1'b1, 1'b1, 1'b0, 4'd7, 32'h0000_00A5, 1'b0, 32'd0, 1'b0);
      tick();
      exp_ret = exp_ret + 32'd1;
      chk_wb("held_alu", 1'b1, 4'd7, 32'h0000_00A5);
      chk("held_alu_retired", bus.retired_o, exp_ret);
      idle_in();
      tick();
      chk_wb("held_alu_hold", 1'b0, 4'd7, 32'h0000_00A5);

      // Store, branch, store: retire without write-back
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b0, 4'(i + 1), 32'h5555_0000, 1'b0, 32'd0, 1'b0);
         tick();
         exp_ret = exp_ret + 32'd1;
         chk_wb("nowrite", 1'b0, 4'd7, 32'h0000_00A5);
      end
      chk("nowrite_retired", bus.retired_o, exp_ret);
      idle_in();

      // Spurious rvalid and err clear priority
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b0);
      tick();
      chk("spur_err", {31'd0, bus.err_o}, 32'd1);
      chk_wb("spur", 1'b0, 4'd7, 32'h0000_00A5);
      chk("spur_retired", bus.retired_o, exp_ret);
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1);
      tick();
      chk("clr_err", {31'd0, bus.err_o}, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 32'd0, 1'b1);
      tick();
      chk("set_wins", {31'd0, bus.err_o}, 32'd1);
      idle_in();
      tick();
      chk("err_sticky", {31'd0, bus.err_o}, 32'd1);
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1);
      tick();
      chk("clr_err2", {31'd0, bus.err_o}, 32'd0);
      idle_in();

`ifdef WB_LOAD_TIMEOUT_EN
      // Load rd=9 abandoned after four wait cycles
      drive(1'b1, 1'b0, 1'b1, 4'd9, 32'd0, 1'b0, 32'd0, 1'b0);
      tick();
      idle_in();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("to_stall", {31'd0, bus.stall_o}, 32'd1);
         chk("to_err_pre", {31'd0, bus.err_o}, 32'd0);
      end
      tick();
      chk("to_stall_end", {31'd0, bus.stall_o}, 32'd0);
      chk("to_err", {31'd0, bus.err_o}, 32'd1);
      chk_wb("to", 1'b0, 4'd7, 32'h0000_00A5);
      chk("to_retired", bus.retired_o, exp_ret);
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1);
      tick();
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 32'h1111_1111, 1'b0);
      tick();
      chk("to_late_err", {31'd0, bus.err_o}, 32'd1);
      chk_wb("to_late", 1'b0, 4'd7, 32'h0000_00A5);
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1);
      tick();
      idle_in();

      // Load rd=10 with rvalid on the terminal cycle
      drive(1'b1, 1'b0, 1'b1, 4'd10, 32'd0, 1'b0, 32'd0, 1'b0);
      tick();
      idle_in();
      tick();
      tick();
      tick();
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 32'h0BAD_F00D, 1'b0);
      tick();
      exp_ret = exp_ret + 32'd1;
      chk_wb("to_edge", 1'b1, 4'd10, 32'h0BAD_F00D);
      chk("to_edge_err", {31'd0, bus.err_o}, 32'd0);
      chk("to_edge_retired", bus.retired_o, exp_ret);
      idle_in();
      tick();
`endif

      // Retire counter wrap, with an r0 write
      force dut.retired_r = 32'hFFFF_FFFF;
      #1;
      release dut.retired_r;
      chk("wrap_pre", bus.retired_o, 32'hFFFF_FFFF);
      drive(1'b1, 1'b1, 1'b0, 4'd0, 32'h0000_0001, 1'b0, 32'd0, 1'b0);
      tick();
      chk("wrap", bus.retired_o, 32'd0);
      chk_wb("r0", 1'b1, 4'd0, 32'h0000_0001);
      idle_in();
      tick();

      // Reset during LOAD_WAIT drops the load
      drive(1'b1, 1'b0, 1'b1, 4'd4, 32'd0, 1'b0, 32'd0, 1'b0);
      tick();
      idle_in();
      chk("rl_stall", {31'd0, bus.stall_o}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk_wb("rl", 1'b0, 4'd0, 32'd0);
      chk("rl_stall_rst", {31'd0, bus.stall_o}, 32'd0);
      chk("rl_retired", bus.retired_o, 32'd0);
      chk("rl_err", {31'd0, bus.err_o}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 32'h2222_2222, 1'b0);
      tick();
      chk("rl_spur_err", {31'd0, bus.err_o}, 32'd1);
      chk_wb("rl_spur", 1'b0, 4'd0, 32'd0);
      chk("rl_spur_retired", bus.retired_o, 32'd0);
      idle_in();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
